// File: rtl/indicator_arbiter.sv
// Three-way owner arbitration of the LED indicator bank: alarm blink over timer chase over mood pass-through.
// All outputs are registered; LED lags OWNER by one clock.
module indicator_arbiter #(
  parameter int unsigned BLINK_TICKS   = 5,
  parameter int unsigned ALARM_TIMEOUT = 600,
  parameter int unsigned TMR_TICKS     = 30
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       TICK,
  input  logic       EN,
  input  logic [2:0] MOOD_LED,
  input  logic       ALARM_REQ,
  input  logic       ALARM_ACK,
  input  logic       TMR_REQ,
  output logic [2:0] LED,
  output logic [1:0] OWNER,
  output logic       ALARM_ACTIVE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TIMER = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [15:0] TO_LIMIT   = 16'(ALARM_TIMEOUT);
  localparam logic [15:0] TMR_LIMIT  = 16'(TMR_TICKS);

  state_t      state_q, state_d;
  logic [2:0]  led_q, led_d;
  logic        alarm_active_q, alarm_active_d;
  logic        tmr_pending_q, tmr_pending_d;
  logic        alarm_hist_q, alarm_hist_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] tmr_cnt_q, tmr_cnt_d;
  logic [1:0]  chase_idx_q, chase_idx_d;

  logic        alarm_edge;
  logic        pend_any;
  logic        alarm_exit;

  always_comb begin
    state_d        = state_q;
    tmr_pending_d  = tmr_pending_q;
    alarm_hist_d   = ALARM_REQ;
    blink_cnt_d    = blink_cnt_q;
    blink_on_d     = blink_on_q;
    to_cnt_d       = to_cnt_q;
    tmr_cnt_d      = tmr_cnt_q;
    chase_idx_d    = chase_idx_q;
    alarm_edge     = ALARM_REQ & ~alarm_hist_q;
    pend_any       = tmr_pending_q | TMR_REQ;
    alarm_exit     = ALARM_ACK | (TICK && (to_cnt_q + 16'd1 == TO_LIMIT));

    unique case (state_q)
      S_IDLE: begin
        if (alarm_edge) begin
          state_d       = S_ALARM;
          blink_on_d    = 1'b1;
          blink_cnt_d   = '0;
          to_cnt_d      = '0;
          tmr_pending_d = pend_any;
        end else if (pend_any) begin
          state_d       = S_TIMER;
          chase_idx_d   = '0;
          tmr_cnt_d     = '0;
          tmr_pending_d = 1'b0;
        end
      end
      S_TIMER: begin
        if (alarm_edge) begin
          // preempted chase is re-run from the start once the alarm releases
          state_d       = S_ALARM;
          blink_on_d    = 1'b1;
          blink_cnt_d   = '0;
          to_cnt_d      = '0;
          tmr_pending_d = 1'b1;
        end else if (TMR_REQ) begin
          chase_idx_d = '0;
          tmr_cnt_d   = '0;
        end else if (TICK) begin
          if (tmr_cnt_q + 16'd1 == TMR_LIMIT) begin
            state_d = S_IDLE;
          end else begin
            tmr_cnt_d   = tmr_cnt_q + 16'd1;
            chase_idx_d = (chase_idx_q == 2'd2) ? 2'd0 : chase_idx_q + 2'd1;
          end
        end
      end
      S_ALARM: begin
        if (alarm_exit) begin
          tmr_pending_d = 1'b0;
          if (pend_any) begin
            state_d     = S_TIMER;
            chase_idx_d = '0;
            tmr_cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_pending_d = pend_any;
          if (TICK) begin
            to_cnt_d = to_cnt_q + 16'd1;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LED pattern follows the registered owner, giving the extra pipeline stage to the pin
  always_comb begin
    led_d = '0;
    unique case (state_q)
      S_IDLE:  led_d = EN ? MOOD_LED : 3'b000;
      S_TIMER: begin
        unique case (chase_idx_q)
          2'd0:    led_d = 3'b001;
          2'd1:    led_d = 3'b010;
          default: led_d = 3'b100;
        endcase
      end
      S_ALARM: led_d = blink_on_q ? 3'b111 : 3'b000;
      default: led_d = '0;
    endcase
    alarm_active_d = (state_d == S_ALARM);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q        <= S_IDLE;
      led_q          <= '0;
      alarm_active_q <= 1'b0;
      tmr_pending_q  <= 1'b0;
      alarm_hist_q   <= 1'b0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b0;
      to_cnt_q       <= '0;
      tmr_cnt_q      <= '0;
      chase_idx_q    <= '0;
    end else begin
      state_q        <= state_d;
      led_q          <= led_d;
      alarm_active_q <= alarm_active_d;
      tmr_pending_q  <= tmr_pending_d;
      alarm_hist_q   <= alarm_hist_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      to_cnt_q       <= to_cnt_d;
      tmr_cnt_q      <= tmr_cnt_d;
      chase_idx_q    <= chase_idx_d;
    end
  end

  assign LED          = led_q;
  assign OWNER        = state_q;
  assign ALARM_ACTIVE = alarm_active_q;

endmodule

// File: tb/tb_indicator_arbiter.sv
// Directed-vector bench for indicator_arbiter with short durations; TICK issued every 4th cycle.
module tb_indicator_arbiter;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       TICK = 1'b0;
  logic       EN = 1'b0;
  logic [2:0] MOOD_LED = 3'b000;
  logic       ALARM_REQ = 1'b0;
  logic       ALARM_ACK = 1'b0;
  logic       TMR_REQ = 1'b0;
  logic [2:0] LED;
  logic [1:0] OWNER;
  logic       ALARM_ACTIVE;

  int unsigned checks = 0;
  int unsigned errors = 0;

  indicator_arbiter #(
    .BLINK_TICKS  (2),
    .ALARM_TIMEOUT(8),
    .TMR_TICKS    (4)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .TICK        (TICK),
    .EN          (EN),
    .MOOD_LED    (MOOD_LED),
    .ALARM_REQ   (ALARM_REQ),
    .ALARM_ACK   (ALARM_ACK),
    .TMR_REQ     (TMR_REQ),
    .LED         (LED),
    .OWNER       (OWNER),
    .ALARM_ACTIVE(ALARM_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // one TICK cycle followed by three quiet cycles
  task automatic tp();
    TICK = 1'b1;
    @(posedge CLK);
    #1;
    TICK = 1'b0;
    cyc(3);
  endtask

  initial begin
    #12;
    check("rst_led", 8'(LED), 8'h0);
    check("rst_owner", 8'(OWNER), 8'h0);
    check("rst_active", 8'(ALARM_ACTIVE), 8'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(2);

    // mood pass-through and EN gating
    MOOD_LED = 3'b010;
    EN = 1'b1;
    cyc(2);
    check("mood_led", 8'(LED), 8'h2);
    check("mood_owner", 8'(OWNER), 8'h0);
    EN = 1'b0;
    cyc(1);
    check("en_off_led", 8'(LED), 8'h0);
    EN = 1'b1;
    cyc(1);

    // timer chase
    TMR_REQ = 1'b1;
    cyc(1);
    TMR_REQ = 1'b0;
    check("tmr_owner", 8'(OWNER), 8'h1);
    check("tmr_active", 8'(ALARM_ACTIVE), 8'h0);
    cyc(1);
    check("chase0", 8'(LED), 8'h1);
    tp();
    check("chase1", 8'(LED), 8'h2);
    tp();
    check("chase2", 8'(LED), 8'h4);
    tp();
    check("chase3", 8'(LED), 8'h1);
    check("tmr_owner3", 8'(OWNER), 8'h1);
    tp();
    check("tmr_done_owner", 8'(OWNER), 8'h0);
    check("tmr_done_led", 8'(LED), 8'h2);

    // alarm blink and timeout, level held high
    ALARM_REQ = 1'b1;
    cyc(1);
    check("alm_owner", 8'(OWNER), 8'h2);
    check("alm_active", 8'(ALARM_ACTIVE), 8'h1);
    cyc(1);
    check("blink_on0", 8'(LED), 8'h7);
    tp();
    check("blink_t1", 8'(LED), 8'h7);
    tp();
    check("blink_t2", 8'(LED), 8'h0);
    tp();
    tp();
    check("blink_t4", 8'(LED), 8'h7);
    tp();
    tp();
    check("blink_t6", 8'(LED), 8'h0);
    tp();
    check("alm_t7_owner", 8'(OWNER), 8'h2);
    tp();
    check("alm_to_owner", 8'(OWNER), 8'h0);
    check("alm_to_active", 8'(ALARM_ACTIVE), 8'h0);
    check("alm_to_led", 8'(LED), 8'h2);
    cyc(8);
    check("no_retrigger", 8'(OWNER), 8'h0);
    ALARM_REQ = 1'b0;
    cyc(1);

    // alarm preempts timer; chase restarts after ACK
    TMR_REQ = 1'b1;
    cyc(1);
    TMR_REQ = 1'b0;
    tp();
    tp();
    check("pre_chase2", 8'(LED), 8'h4);
    ALARM_REQ = 1'b1;
    cyc(1);
    check("preempt_owner", 8'(OWNER), 8'h2);
    cyc(1);
    check("preempt_led", 8'(LED), 8'h7);
    tp();
    tp();
    tp();
    ALARM_ACK = 1'b1;
    cyc(1);
    ALARM_ACK = 1'b0;
    ALARM_REQ = 1'b0;
    check("ack_to_tmr", 8'(OWNER), 8'h1);
    cyc(1);
    check("restart_chase0", 8'(LED), 8'h1);
    tp();
    check("restart_chase1", 8'(LED), 8'h2);
    tp();
    tp();
    check("restart_t3_owner", 8'(OWNER), 8'h1);
    tp();
    check("restart_done", 8'(OWNER), 8'h0);

    // simultaneous alarm edge and timer request
    ALARM_REQ = 1'b1;
    TMR_REQ = 1'b1;
    cyc(1);
    TMR_REQ = 1'b0;
    check("simul_owner", 8'(OWNER), 8'h2);
    tp();
    ALARM_ACK = 1'b1;
    cyc(1);
    ALARM_ACK = 1'b0;
    ALARM_REQ = 1'b0;
    check("simul_tmr", 8'(OWNER), 8'h1);
    tp();
    tp();
    tp();
    tp();
    check("simul_done", 8'(OWNER), 8'h0);
    ALARM_ACK = 1'b1;
    cyc(1);
    ALARM_ACK = 1'b0;
    cyc(1);
    check("ack_idle_owner", 8'(OWNER), 8'h0);
    check("ack_idle_led", 8'(LED), 8'h2);

    // async reset mid-alarm, release with ALARM_REQ high
    ALARM_REQ = 1'b1;
    cyc(3);
    check("pre_rst_owner", 8'(OWNER), 8'h2);
    RSTN = 1'b0;
    #1;
    check("arst_led", 8'(LED), 8'h0);
    check("arst_owner", 8'(OWNER), 8'h0);
    check("arst_active", 8'(ALARM_ACTIVE), 8'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc(1);
    check("rel_owner", 8'(OWNER), 8'h2);
    for (int unsigned i = 0; i < 8; i++) tp();
    check("rel_to_owner", 8'(OWNER), 8'h0);
    cyc(4);
    check("rel_once", 8'(OWNER), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
